twiddle_addr_gen: RTL and testbench
===================================

TWIDDLE_ADDR_GEN -- requirements
Module: twiddle_addr_gen

Interface
REQ-001 Parameter N, default 16: FFT length; power of two, N >= 4.
REQ-002 Parameter S, default $clog2(N): number of radix-2 stages; derived, not overridden.
REQ-003 clk  input  1: single clock; all state updates on posedge.
REQ-004 rst_n  input  1: reset, asynchronous, active-low.
REQ-005 start  input  1: one-cycle request to sequence one full FFT; sampled only in IDLE.
REQ-006 ready  input  1: downstream butterfly accepts the presented butterfly.
REQ-007 read_address  output  $clog2(N): twiddle index to the twiddle ROM (1-cycle read latency).
REQ-008 bf_valid  output  1: bf_* outputs and ROM twiddle_real/twiddle_im are valid and mutually aligned.
REQ-009 bf_idx_a  output  $clog2(N): upper data index of the presented butterfly.
REQ-010 bf_idx_b  output  $clog2(N): lower data index of the presented butterfly.
REQ-011 bf_stage  output  $clog2(S): stage of the presented butterfly.
REQ-012 busy  output  1: high from start acceptance until done.
REQ-013 done  output  1: one-cycle pulse after the last butterfly is accepted.

Function
REQ-014 Radix-2 DIT ordering: stage s = 0..S-1 outer, butterfly j = 0..N/2-1 inner; S*N/2 butterflies total.
REQ-015 Per butterfly: half = 2^s, p = j mod half, g = j / half; idx_a = 2*half*g + p; idx_b = idx_a + half; twiddle k = p << (S-1-s).
REQ-016 Two-slot pipeline: issue slot (counters s, j, issue_valid) and present slot (bf_* registers, bf_valid).
REQ-017 Pipeline enable en = ready OR NOT bf_valid; when en, present slot loads issue slot and issue slot advances; when not en, both hold.
REQ-018 read_address is combinational: k of issue slot when en, else k of present slot, so the 1-cycle ROM output always matches bf_* at bf_valid.
REQ-019 A butterfly is transferred exactly when bf_valid AND ready; no butterfly dropped or repeated under any ready pattern.
REQ-020 FSM states IDLE, RUN, DRAIN. IDLE->RUN on start (busy set); RUN->DRAIN when last butterfly (s=S-1, j=N/2-1) leaves issue slot; DRAIN->IDLE when that butterfly transfers, with done pulsed in the following cycle and busy low from that cycle.
REQ-021 start while busy is ignored; start coincident with the done pulse is ignored.
REQ-022 Counter wrap: j wraps N/2-1 -> 0 and increments s; s never exceeds S-1.
REQ-023 In IDLE: issue_valid = 0, bf_valid = 0, read_address = 0.

Reset
REQ-024 rst_n low asynchronously forces IDLE, s = 0, j = 0, issue_valid = 0, bf_valid = 0, busy = 0, done = 0, bf_idx_a = bf_idx_b = bf_stage = 0.
REQ-025 Reset mid-operation aborts the FFT with no done pulse; next start restarts from stage 0, butterfly 0.
REQ-026 Reset deassertion has no side effects; first start is accepted the first cycle after rst_n high.

Structure
REQ-027 Shared package fft_pkg holds the FSM state enum and log2/width helper constants used by all FFT blocks.
REQ-028 No sub-module; the twiddle ROM is instantiated beside this block by the parent, read_address wired to its read_address port.

Verification
REQ-029 N=16, ready held 1, start pulse at cycle 0 -> bf_valid first at cycle 2; 32 consecutive butterflies; done pulse at cycle 34; busy low at cycle 34.
REQ-030 N=16 index spot checks -> stage0 j0: a=0 b=1 k=0; stage1 j1: a=1 b=3 k=4; stage2 j5: a=9 b=13 k=2; stage3 j7: a=7 b=15 k=7.
REQ-031 ready low for 3 cycles while stage1 j1 is presented -> bf_* and ROM twiddle output hold (k=4) for all 3 cycles; next butterfly (stage1 j2: a=4 b=6 k=0) follows with no skip.
REQ-032 Random ready (50%) over full FFT against reference model -> exactly 32 transfers, in order, each twiddle matching ROM[k]; one done pulse.
REQ-033 rst_n low at butterfly 10, then start -> no done from aborted run; first transfer of the new run is stage0 j0.
REQ-034 start pulsed at cycles 5 and 20 during a run -> ignored; still exactly 32 transfers and one done.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared FFT definitions: sequencer state encoding and width helpers.
package fft_pkg;

  localparam int FFT_STATE_W = 2;

  typedef logic [FFT_STATE_W-1:0] fft_state_t;

  localparam fft_state_t FFT_IDLE  = 2'd0;
  localparam fft_state_t FFT_RUN   = 2'd1;
  localparam fft_state_t FFT_DRAIN = 2'd2;

  // Width of a field holding 0..n-1; never narrower than one bit.
  function automatic int fft_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/twiddle_addr_gen.sv
// Radix-2 DIT butterfly sequencer: presents data index pairs and drives the
// twiddle ROM address so the ROM output lines up with the presented butterfly.
//
// state     | meaning
// ----------+----------------------------------------------------------
// FFT_IDLE  | waiting for start; issue and present slots empty
// FFT_RUN   | issue slot walking stages/butterflies into present slot
// FFT_DRAIN | last butterfly presented, waiting for it to be accepted
module twiddle_addr_gen
  import fft_pkg::*;
#(
  parameter int N = 16,
  localparam int S = $clog2(N),
  localparam int W = $clog2(N),
  localparam int SW = fft_width(S)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          ready,
  output logic [W-1:0]  read_address,
  output logic          bf_valid,
  output logic [W-1:0]  bf_idx_a,
  output logic [W-1:0]  bf_idx_b,
  output logic [SW-1:0] bf_stage,
  output logic          busy,
  output logic          done
);

  localparam logic [SW-1:0] S_LAST = SW'(S - 1);
  localparam logic [W-2:0]  J_LAST = '1;

  fft_state_t    state;
  logic [SW-1:0] s_cnt;
  logic [W-2:0]  j_cnt;
  logic          issue_valid;
  logic          en;
  logic          accept;
  logic          last_issue;
  logic [W-1:0]  j_ext, half, p_val, g_val;
  logic [W-1:0]  iss_a, iss_b, iss_k;
  logic [W-1:0]  bf_k;

  always_comb begin
    j_ext = W'(j_cnt);
    half  = W'(1) << s_cnt;
    p_val = j_ext & (half - W'(1));
    g_val = j_ext >> s_cnt;
    iss_a = ((g_val << s_cnt) << 1) | p_val;
    iss_b = iss_a | half;
    iss_k = p_val << (S_LAST - s_cnt);
  end

  assign en         = ready | ~bf_valid;
  assign accept     = (state == FFT_IDLE) && start && !done;
  assign last_issue = issue_valid && (s_cnt == S_LAST) && (j_cnt == J_LAST);

  // Address the entry that will be presented next cycle, so the ROM's
  // one-cycle latency lands on the same cycle as the bf_* registers.
  assign read_address = en ? (issue_valid ? iss_k : '0) : bf_k;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= FFT_IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        FFT_IDLE: begin
          if (accept) begin
            state <= FFT_RUN;
            busy  <= 1'b1;
          end
        end
        FFT_RUN: begin
          if (en && last_issue) state <= FFT_DRAIN;
        end
        FFT_DRAIN: begin
          if (bf_valid && ready) begin
            state <= FFT_IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: begin
          state <= FFT_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_cnt       <= '0;
      j_cnt       <= '0;
      issue_valid <= 1'b0;
      bf_valid    <= 1'b0;
      bf_idx_a    <= '0;
      bf_idx_b    <= '0;
      bf_stage    <= '0;
      bf_k        <= '0;
    end else begin
      if (en) begin
        bf_valid <= issue_valid;
        if (issue_valid) begin
          bf_idx_a <= iss_a;
          bf_idx_b <= iss_b;
          bf_stage <= s_cnt;
          bf_k     <= iss_k;
          if (last_issue) begin
            issue_valid <= 1'b0;
            s_cnt       <= '0;
            j_cnt       <= '0;
          end else begin
            j_cnt <= j_cnt + 1'b1;
            if (j_cnt == J_LAST) s_cnt <= s_cnt + 1'b1;
          end
        end
      end
      if (accept) begin
        issue_valid <= 1'b1;
        s_cnt       <= '0;
        j_cnt       <= '0;
      end
    end
  end

endmodule

// File: tb/tb_twiddle_addr_gen.sv
// Scoreboard bench for twiddle_addr_gen with N=16 and a behavioural twiddle ROM.
module tb_twiddle_addr_gen;

  localparam int N  = 16;
  localparam int W  = 4;
  localparam int SW = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          ready = 1'b0;
  logic [W-1:0]  read_address;
  logic          bf_valid;
  logic [W-1:0]  bf_idx_a;
  logic [W-1:0]  bf_idx_b;
  logic [SW-1:0] bf_stage;
  logic          busy;
  logic          done;
  logic [15:0]   rom_q;

  twiddle_addr_gen #(.N(N)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .ready(ready),
    .read_address(read_address), .bf_valid(bf_valid),
    .bf_idx_a(bf_idx_a), .bf_idx_b(bf_idx_b), .bf_stage(bf_stage),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] rom_val(input int k);
    return 16'(16'h5A00 + k * 37);
  endfunction

  always_ff @(posedge clk) rom_q <= rom_val(int'(read_address));

  typedef struct {int a; int b; int s; int k;} exp_t;
  exp_t exp_q[$];

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  int t0 = 0;
  int xfer_cnt = 0;
  int done_cnt = 0;
  int done_cyc = -1;
  int first_valid_cyc = -1;

  // hand-computed spot checks: transfer number, a, b, stage, k
  int spot_n[5] = '{0, 9, 10, 21, 31};
  int spot_a[5] = '{0, 1, 4, 9, 7};
  int spot_b[5] = '{1, 3, 6, 13, 15};
  int spot_s[5] = '{0, 1, 1, 2, 3};
  int spot_k[5] = '{0, 4, 0, 2, 7};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference order built per group/offset rather than by butterfly counter.
  task automatic push_run();
    for (int s = 0; s < 4; s++) begin
      int half = 1 << s;
      for (int g = 0; g < N / (2 * half); g++)
        for (int p = 0; p < half; p++) begin
          exp_t e;
          e.a = g * 2 * half + p;
          e.b = e.a + half;
          e.s = s;
          e.k = p * (N / (2 * half));
          exp_q.push_back(e);
        end
    end
  endtask

  task automatic arm();
    t0 = cyc;
    xfer_cnt = 0;
    done_cnt = 0;
    done_cyc = -1;
    first_valid_cyc = -1;
  endtask

  always @(negedge clk) begin
    if (bf_valid && first_valid_cyc < 0) first_valid_cyc = cyc - t0;
    if (bf_valid && ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_transfer", xfer_cnt, -1);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("idx_a", int'(bf_idx_a), e.a);
        chk("idx_b", int'(bf_idx_b), e.b);
        chk("stage", int'(bf_stage), e.s);
        chk("twiddle", int'(rom_q), int'(rom_val(e.k)));
      end
      for (int i = 0; i < 5; i++)
        if (spot_n[i] == xfer_cnt) begin
          chk("spot_a", int'(bf_idx_a), spot_a[i]);
          chk("spot_b", int'(bf_idx_b), spot_b[i]);
          chk("spot_stage", int'(bf_stage), spot_s[i]);
          chk("spot_twiddle", int'(rom_q), int'(rom_val(spot_k[i])));
        end
      xfer_cnt++;
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc - t0;
      chk("busy_at_done", int'(busy), 0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input int budget, input bit rnd);
    int i;
    for (i = 0; i < budget; i++) begin
      if (rnd) ready = 1'($urandom_range(0, 1));
      tick();
      if (done_cnt > 0) break;
    end
    if (i == budget) chk("done_timeout", 0, 1);
    ready = 1'b1;
    tick();
  endtask

  task automatic launch();
    push_run();
    arm();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic end_of_run(input string tag);
    chk({tag, "_xfers"}, xfer_cnt, 32);
    chk({tag, "_dones"}, done_cnt, 1);
    chk({tag, "_queue_left"}, exp_q.size(), 0);
    chk({tag, "_busy_after"}, int'(busy), 0);
    exp_q.delete();
  endtask

  initial begin
    int i;
    #2;
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_valid", int'(bf_valid), 0);
    chk("rst_addr", int'(read_address), 0);
    chk("rst_idx_a", int'(bf_idx_a), 0);
    chk("rst_idx_b", int'(bf_idx_b), 0);
    chk("rst_stage", int'(bf_stage), 0);
    tick();
    tick();
    rst_n = 1'b1;
    ready = 1'b1;
    tick();

    // full run, ready held high
    launch();
    wait_done(80, 1'b0);
    chk("first_valid_cycle", first_valid_cyc, 2);
    chk("done_cycle", done_cyc, 34);
    end_of_run("run1");
    chk("idle_addr", int'(read_address), 0);

    // backpressure on stage1 j1
    launch();
    for (i = 0; i < 100; i++) begin
      if (bf_valid && bf_stage == 2'd1 && bf_idx_a == 4'd1) break;
      tick();
    end
    if (i == 100) chk("stall_point_timeout", 0, 1);
    ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("stall_a", int'(bf_idx_a), 1);
      chk("stall_b", int'(bf_idx_b), 3);
      chk("stall_valid", int'(bf_valid), 1);
      chk("stall_twiddle", int'(rom_q), int'(rom_val(4)));
      tick();
    end
    ready = 1'b1;
    wait_done(80, 1'b0);
    end_of_run("stall");

    // random ready
    launch();
    wait_done(400, 1'b1);
    end_of_run("random");

    // reset mid-run
    launch();
    for (i = 0; i < 100; i++) begin
      if (xfer_cnt >= 10) break;
      tick();
    end
    if (i == 100) chk("abort_point_timeout", 0, 1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_busy", int'(busy), 0);
    chk("async_rst_valid", int'(bf_valid), 0);
    exp_q.delete();
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    chk("aborted_dones", done_cnt, 0);
    chk("aborted_busy", int'(busy), 0);
    launch();
    wait_done(80, 1'b0);
    chk("restart_first_valid", first_valid_cyc, 2);
    end_of_run("restart");

    // start pulses during run and on the done cycle are ignored
    launch();
    for (int c = 1; c <= 40; c++) begin
      start = (c == 5 || c == 20 || c == 34);
      tick();
    end
    start = 1'b0;
    chk("ignored_done_cycle", done_cyc, 34);
    chk("ignored_valid_after", int'(bf_valid), 0);
    end_of_run("ignored");

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
